// File: rtl/apb_uart_completer.sv
// APB completer for the UART block: CTRL/TXDATA/RXDATA/STATUS registers, TX launch and RX FIFO.
// Optional feature: define UART_LOOPBACK_EN to make CTRL[4] steer accepted TX bytes into the RX FIFO.
module apb_uart_completer #(
    parameter int WAIT_STATES = 0,
    parameter int RX_DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        apb_psel,
    input  logic        apb_penable,
    input  logic        apb_pwrite,
    input  logic [4:0]  apb_paddr,
    input  logic [31:0] apb_pwdata,
    output logic [31:0] apb_prdata,
    output logic        apb_pready,
    output logic        apb_pslverr,
    output logic [7:0]  uart_data_out,
    output logic        uart_send,
    output logic [1:0]  uart_baud_rate,
    output logic [1:0]  uart_parity_type,
    input  logic        uart_tx_active,
    input  logic        uart_tx_done,
    input  logic        uart_rx_done,
    input  logic [7:0]  uart_data_in,
    input  logic [2:0]  uart_error
);

    localparam int AW = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_TXDATA = 3'd1,
        REG_RXDATA = 3'd2,
        REG_STATUS = 3'd3
    } reg_e;

    logic [2:0]    wcnt;
    logic [3:0]    ctrl_q;
    logic          tx_busy;
    logic          ovr_q;
    logic [2:0]    err_q;
    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          loopback;

    logic          commit;
    logic          bad;
    logic [31:0]   rdata;
    reg_e          reg_sel;
    logic          fifo_empty;
    logic          fifo_full;
    logic          ctrl_wr;
    logic          tx_wr;
    logic          status_wr;
    logic          rx_pop;
    logic          push_req;
    logic          push_ok;
    logic [7:0]    push_data;

`ifdef UART_LOOPBACK_EN
    logic lb_q;
    assign loopback = lb_q;
`else
    assign loopback = 1'b0;
`endif

    // Reset gates completion so a transfer caught by reset has no side effect.
    assign apb_pready = apb_psel & apb_penable & (wcnt == 3'(WAIT_STATES)) & ~i_rst;
    assign commit     = apb_pready;
    assign reg_sel    = reg_e'(apb_paddr[4:2]);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rdata = '0;
        bad   = 1'b0;
        if (apb_paddr[1:0] != 2'b00) begin
            bad = 1'b1;
        end else begin
            case (reg_sel)
                REG_CTRL:   rdata = {27'd0, loopback, ctrl_q};
                REG_TXDATA: begin
                    rdata = {24'd0, uart_data_out};
                    bad   = apb_pwrite & tx_busy;
                end
                REG_RXDATA: begin
                    rdata = {24'd0, fifo_mem[rd_ptr[AW-1:0]]};
                    bad   = apb_pwrite | fifo_empty;
                end
                REG_STATUS: rdata = {25'd0, err_q, ovr_q, fifo_full, ~fifo_empty,
                                     tx_busy | uart_tx_active};
                default:    bad = 1'b1;
            endcase
        end
    end

    assign apb_prdata  = (commit & ~bad & ~apb_pwrite) ? rdata : 32'd0;
    assign apb_pslverr = commit & bad;

    assign ctrl_wr   = commit & ~bad &  apb_pwrite & (reg_sel == REG_CTRL);
    assign tx_wr     = commit & ~bad &  apb_pwrite & (reg_sel == REG_TXDATA);
    assign status_wr = commit & ~bad &  apb_pwrite & (reg_sel == REG_STATUS);
    assign rx_pop    = commit & ~bad & ~apb_pwrite & (reg_sel == REG_RXDATA);

    // In loopback the receiver is ignored and accepted TX bytes feed the FIFO instead.
    assign push_req  = loopback ? tx_wr : uart_rx_done;
    assign push_data = loopback ? apb_pwdata[7:0] : uart_data_in;
    assign push_ok   = push_req & (~fifo_full | rx_pop);

    assign uart_baud_rate   = ctrl_q[1:0];
    assign uart_parity_type = ctrl_q[3:2];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wcnt          <= '0;
            ctrl_q        <= '0;
            tx_busy       <= 1'b0;
            ovr_q         <= 1'b0;
            err_q         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            uart_data_out <= '0;
            uart_send     <= 1'b0;
`ifdef UART_LOOPBACK_EN
            lb_q          <= 1'b0;
`endif
        end else begin
            if (!apb_psel || commit)
                wcnt <= '0;
            else if (apb_penable)
                wcnt <= wcnt + 3'd1;

            if (ctrl_wr) begin
                ctrl_q <= apb_pwdata[3:0];
`ifdef UART_LOOPBACK_EN
                lb_q   <= apb_pwdata[4];
`endif
            end

            uart_send <= tx_wr & ~loopback;
            if (tx_wr)
                uart_data_out <= apb_pwdata[7:0];
            if (tx_wr && !loopback)
                tx_busy <= 1'b1;
            else if (uart_tx_done)
                tx_busy <= 1'b0;

            // Sticky set is OR-ed after the clear so a same-cycle event survives W1C.
            ovr_q <= (ovr_q & ~(status_wr & apb_pwdata[3])) | (push_req & fifo_full & ~rx_pop);
            err_q <= (err_q & ~({3{status_wr}} & apb_pwdata[6:4])) | uart_error;

            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rx_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_ok)
            fifo_mem[wr_ptr[AW-1:0]] <= push_data;
    end

    logic unused_pwdata;
    assign unused_pwdata = ^apb_pwdata[31:8];

endmodule
